// File: rtl/pattern_arbiter_pkg.sv
// Shared types and constants for the pattern arbiter: FSM states, the
// decoded pattern table, and the code-to-pattern mapping.
package pattern_arbiter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SHOW = 1'b1
   } state_t;

   localparam logic [7:0] PAT_C1  = 8'h96;
   localparam logic [7:0] PAT_C2  = 8'h8E;
   localparam logic [7:0] PAT_C3  = 8'hE5;
   localparam logic [7:0] PAT_DEF = 8'h00;

   function automatic logic [7:0] decode(input logic [3:0] code);
      case (code)
         4'd1:    return PAT_C1;
         4'd2:    return PAT_C2;
         4'd3:    return PAT_C3;
         default: return PAT_DEF;
      endcase
   endfunction

endpackage

// File: rtl/pattern_arbiter_decoder.sv
// Combinational 4-bit code to 8-bit pattern decoder; unmapped codes give 0x00.
module code_decoder
   import pattern_arbiter_pkg::*;
(
   input  logic [3:0] code,
   output logic [7:0] pattern
);

   assign pattern = decode(code);

endmodule

// File: rtl/pattern_arbiter.sv
// Round-robin arbiter: grants one requester at a time, decodes its code and
// presents the pattern for at least HOLD_CYC cycles until the consumer accepts.
module pattern_arbiter
   import pattern_arbiter_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int HOLD_CYC = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [4*N_REQ-1:0]         req_code,
   output logic [N_REQ-1:0]           req_ready,
   output logic                       out_valid,
   output logic [7:0]                 out_pattern,
   output logic [$clog2(N_REQ)-1:0]   out_id,
   input  logic                       out_ready,
   output logic                       busy
);

   localparam int         IDW      = $clog2(N_REQ);
   localparam logic [3:0] HOLD_MAX = 4'(HOLD_CYC - 1);

   state_t           state;
   logic [IDW-1:0]   rr_ptr;
   logic [3:0]       hold_cnt;

   logic [3:0]       codes [N_REQ];
   logic             win_found;
   logic [IDW-1:0]   win_idx;
   logic [IDW-1:0]   rr_next;
   logic [3:0]       win_code;
   logic [7:0]       dec_pattern;
   logic             complete;
   logic             grant_en;
   logic             grant;
   logic [N_REQ-1:0] win_onehot;
   int               j;

   for (genvar i = 0; i < N_REQ; i++) begin : g_codes
      assign codes[i] = req_code[4*i +: 4];
   end

   // First valid requester at or after rr_ptr, wrapping around.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      j         = 0;
      for (int k = 0; k < N_REQ; k++) begin
         j = (int'(rr_ptr) + k) % N_REQ;
         if (!win_found && req_valid[j]) begin
            win_found = 1'b1;
            win_idx   = j[IDW-1:0];
         end
      end
   end

   always_comb begin
      win_onehot          = '0;
      win_onehot[win_idx] = 1'b1;
   end

   assign win_code = codes[win_idx];
   assign rr_next  = (win_idx == IDW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

   code_decoder u_dec (
      .code    (win_code),
      .pattern (dec_pattern)
   );

   // Consumer acceptance only counts once the minimum hold time has elapsed.
   assign complete  = (state == SHOW) && out_ready && (hold_cnt == HOLD_MAX);
   // reset_n gates the grant so req_ready drops the instant reset asserts.
   assign grant_en  = reset_n && ((state == IDLE) || complete);
   assign grant     = grant_en && win_found;
   assign req_ready = grant ? win_onehot : '0;
   assign busy      = (state == SHOW);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         hold_cnt    <= '0;
         out_valid   <= 1'b0;
         out_pattern <= PAT_DEF;
         out_id      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant) begin
                  state       <= SHOW;
                  hold_cnt    <= '0;
                  out_valid   <= 1'b1;
                  out_pattern <= dec_pattern;
                  out_id      <= win_idx;
                  rr_ptr      <= rr_next;
               end
            end
            SHOW: begin
               if (grant) begin
                  hold_cnt    <= '0;
                  out_pattern <= dec_pattern;
                  out_id      <= win_idx;
                  rr_ptr      <= rr_next;
               end else if (complete) begin
                  state       <= IDLE;
                  hold_cnt    <= '0;
                  out_valid   <= 1'b0;
               end else if (hold_cnt != HOLD_MAX) begin
                  hold_cnt    <= hold_cnt + 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
